// File: rtl/pipe_ctrl_pkg.sv
// Shared stage-control encodings and helpers for the Y86 pipeline register chain.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_NORMAL = 2'd0,
    CTRL_STALL  = 2'd1,
    CTRL_BUBBLE = 2'd2,
    CTRL_RSVD   = 2'd3
  } pipe_ctrl_t;

  localparam logic [3:0] NOP_ICODE = 4'h1;

  // A normal stage directly below a stalled one must bubble, or the held
  // instruction would be duplicated downstream. Reserved codes act as bubbles.
  function automatic pipe_ctrl_t resolve_ctrl(input pipe_ctrl_t raw, input logic up_stall);
    pipe_ctrl_t eff;
    eff = raw;
    if (raw == CTRL_RSVD) begin
      eff = CTRL_BUBBLE;
    end else if (up_stall && (raw == CTRL_NORMAL)) begin
      eff = CTRL_BUBBLE;
    end
    return eff;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register stage: load upstream, hold, or load a bubble.
module pipe_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int                DATA_W     = 128,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {NOP_ICODE, {(DATA_W-4){1'b0}}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic              up_valid_i,
  input  pipe_ctrl_t        ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    case (ctrl_i)
      CTRL_NORMAL: begin
        data_d  = up_data_i;
        valid_d = up_valid_i;
      end
      CTRL_STALL: begin
        data_d  = data_q;
        valid_d = valid_q;
      end
      default: begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Chain of STAGES pipeline registers with auto-bubble below stalls.
// Define PIPE_STATS_EN to build the saturating stall/bubble counters.
module pipe_stage_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int                STAGES     = 4,
  parameter int                DATA_W     = 128,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {NOP_ICODE, {(DATA_W-4){1'b0}}},
  parameter int                CNT_W      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic [2*STAGES-1:0]      ctrl,
  output logic [STAGES*DATA_W-1:0] out_data,
  output logic [STAGES-1:0]        out_valid,
  output logic                     ctrl_err,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         bubble_cnt
);

  pipe_ctrl_t eff [STAGES];
  logic       rsvd_seen;
  logic       err_q, err_d;

  // Effective control ripples top-down so each stage sees its upstream's resolved state.
  always_comb begin : eff_derive
    logic       up_stall;
    pipe_ctrl_t raw;
    up_stall  = 1'b0;
    rsvd_seen = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      raw       = pipe_ctrl_t'(ctrl[2*i +: 2]);
      rsvd_seen = rsvd_seen | (raw == CTRL_RSVD);
      eff[i]    = resolve_ctrl(raw, up_stall);
      up_stall  = (eff[i] == CTRL_STALL);
    end
  end

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
      logic [DATA_W-1:0] up_data;
      logic              up_valid;
      if (gi == 0) begin : gen_head
        assign up_data  = in_data;
        assign up_valid = in_valid;
      end else begin : gen_body
        assign up_data  = out_data[DATA_W*gi-1 -: DATA_W];
        assign up_valid = out_valid[gi-1];
      end
      pipe_stage #(
        .DATA_W     (DATA_W),
        .BUBBLE_VAL (BUBBLE_VAL)
      ) u_stage (
        .clock      (clock),
        .reset      (reset),
        .up_data_i  (up_data),
        .up_valid_i (up_valid),
        .ctrl_i     (eff[gi]),
        .data_o     (out_data[DATA_W*(gi+1)-1 -: DATA_W]),
        .valid_o    (out_valid[gi])
      );
    end
  endgenerate

  assign err_d = err_q | rsvd_seen;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ctrl_err = err_q;

`ifdef PIPE_STATS_EN
  localparam int SEL_W = $clog2(STAGES + 1);
  // Wide enough that the counter maximum plus a full per-edge sum cannot overflow.
  localparam int SUM_W = CNT_W + SEL_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [SEL_W-1:0] n_stall, n_bubble;
  logic [SUM_W-1:0] stall_sum, bubble_sum;
  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    n_stall  = '0;
    n_bubble = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (eff[i] == CTRL_STALL)  n_stall  = n_stall + SEL_W'(1);
      if (eff[i] == CTRL_BUBBLE) n_bubble = n_bubble + SEL_W'(1);
    end
    stall_sum  = SUM_W'(stall_q) + SUM_W'(n_stall);
    bubble_sum = SUM_W'(bubble_q) + SUM_W'(n_bubble);
    stall_d    = (stall_sum  > CNT_MAX) ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
    bubble_d   = (bubble_sum > CNT_MAX) ? {CNT_W{1'b1}} : bubble_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
